// File: rtl/mips_cpu_muldiv_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_muldiv_pkg : shared types and constants for the HI/LO unit |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WB   = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } muldiv_state_t;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_muldiv_ctrl_if : pipeline and multiplier hookup for HI/LO  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface mips_cpu_muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        stall;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_sign;
  logic [63:0] mult_r;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  op_valid, op, rs_val, rt_val, rd_req, rd_sel, mult_r,
    output rd_data, rd_valid, busy, stall, mult_a, mult_b, mult_sign, hi, lo
  );

  modport master (
    output op_valid, op, rs_val, rt_val, rd_req, rd_sel, mult_r,
    input  rd_data, rd_valid, busy, stall, mult_a, mult_b, mult_sign, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv_ctrl_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_div_core : 32-step unsigned restoring divider              |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module mips_cpu_div_core
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  logic [31:0] dsor;
  logic [4:0]  step;
  logic        running;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // quot doubles as the dividend shift register; a zero divisor naturally yields all-ones
  always_comb begin
    rem_sh = {rem, quot[31]};
    diff   = rem_sh - {1'b0, dsor};
  end

  assign done = running && (step == 5'(DIV_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot    <= '0;
      rem     <= '0;
      dsor    <= '0;
      step    <= '0;
      running <= 1'b0;
    end else if (start) begin
      quot    <= dividend;
      rem     <= '0;
      dsor    <= divisor;
      step    <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (!diff[32]) begin
        rem  <= diff[31:0];
        quot <= {quot[30:0], 1'b1};
      end else begin
        rem  <= rem_sh[31:0];
        quot <= {quot[30:0], 1'b0};
      end
      step <= step + 5'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_muldiv_ctrl : HI/LO sequencer (mul hookup, divider, MT/MF) |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module mips_cpu_muldiv_ctrl
  import mips_cpu_muldiv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  mips_cpu_muldiv_ctrl_if.slave   bus
);

  muldiv_state_t state;
  muldiv_op_t    op_in;
  logic [31:0]   hi_reg, lo_reg;
  logic [31:0]   mul_a_hold, mul_b_hold;
  logic          mul_sign_hold;
  logic          q_neg, r_neg;
  logic          idle, is_div, is_sdiv, div_start, div_done;
  logic [31:0]   div_quot, div_rem, div_a, div_b;

  assign op_in     = muldiv_op_t'(bus.op);
  assign idle      = (state == IDLE);
  assign is_sdiv   = (op_in == OP_DIV);
  assign is_div    = is_sdiv || (op_in == OP_DIVU);
  assign div_start = bus.op_valid && idle && is_div;
  assign div_a     = is_sdiv ? abs32(bus.rs_val) : bus.rs_val;
  assign div_b     = is_sdiv ? abs32(bus.rt_val) : bus.rt_val;

  mips_cpu_div_core u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  // operands flow straight through while idle so the multiplier captures them on the accept edge
  assign bus.mult_a    = idle ? (bus.op_valid ? bus.rs_val : 32'd0) : mul_a_hold;
  assign bus.mult_b    = idle ? (bus.op_valid ? bus.rt_val : 32'd0) : mul_b_hold;
  assign bus.mult_sign = idle ? (bus.op_valid && op_in == OP_MULT) : mul_sign_hold;

  assign bus.busy     = !idle;
  assign bus.stall    = !idle && (bus.op_valid || bus.rd_req);
  assign bus.rd_valid = bus.rd_req && idle;
  assign bus.rd_data  = bus.rd_sel ? hi_reg : lo_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hi_reg        <= '0;
      lo_reg        <= '0;
      mul_a_hold    <= '0;
      mul_b_hold    <= '0;
      mul_sign_hold <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (op_in)
              OP_MULT, OP_MULTU: begin
                mul_a_hold    <= bus.rs_val;
                mul_b_hold    <= bus.rt_val;
                mul_sign_hold <= (op_in == OP_MULT);
                state         <= MUL_WB;
              end
              OP_DIV, OP_DIVU: begin
                q_neg <= is_sdiv && (bus.rs_val[31] ^ bus.rt_val[31]);
                r_neg <= is_sdiv && bus.rs_val[31];
                state <= DIV_RUN;
              end
              OP_MTHI: hi_reg <= bus.rs_val;
              OP_MTLO: lo_reg <= bus.rs_val;
              default: ;
            endcase
          end
        end
        MUL_WB: begin
          {hi_reg, lo_reg} <= bus.mult_r;
          state            <= IDLE;
        end
        DIV_RUN: begin
          if (div_done) state <= DIV_DONE;
        end
        DIV_DONE: begin
          lo_reg <= q_neg ? (32'd0 - div_quot) : div_quot;
          hi_reg <= r_neg ? (32'd0 - div_rem) : div_rem;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_mips_cpu_muldiv_ctrl : directed self-checking bench             |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_mips_cpu_muldiv_ctrl;
  import mips_cpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  mips_cpu_muldiv_ctrl_if bus();

  mips_cpu_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // external one-cycle registered multiplier
  always @(posedge clk) begin
    if (bus.mult_sign)
      bus.mult_r <= {{32{bus.mult_a[31]}}, bus.mult_a} * {{32{bus.mult_b[31]}}, bus.mult_b};
    else
      bus.mult_r <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.stall, bus.rd_valid, bus.mult_sign} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.stall, bus.rd_valid, bus.mult_sign});
    else passed++;
    checks++;
    if ({bus.hi, bus.lo, bus.rd_data} !== 96'd0)
      $display("FAIL reset_hilo: got hi=%h lo=%h rd=%h expected 0", bus.hi, bus.lo, bus.rd_data);
    else passed++;
    checks++;
    if ({bus.mult_a, bus.mult_b} !== 64'd0)
      $display("FAIL reset_mult_ops: got %h expected 0", {bus.mult_a, bus.mult_b});
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rs_val   = 32'hFFFF_FFFE;
    bus.rt_val   = 32'd3;
    #1;
    checks++;
    if ({bus.mult_a, bus.mult_b, bus.mult_sign} !== {32'hFFFF_FFFE, 32'd3, 1'b1})
      $display("FAIL mult_passthru: got a=%h b=%h s=%b expected fffffffe 3 1", bus.mult_a, bus.mult_b, bus.mult_sign);
    else passed++;
    tick();
    bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL mult_busy_on: got %b expected 1", bus.busy);
    else passed++;
    tick();
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA})
      $display("FAIL mult_result: got busy=%b hi=%h lo=%h expected 0 ffffffff fffffffa", bus.busy, bus.hi, bus.lo);
    else passed++;

    bus.op_valid = 1'b1;
    bus.op       = OP_MULTU;
    #1;
    checks++;
    if (bus.mult_sign !== 1'b0) $display("FAIL multu_sign: got %b expected 0", bus.mult_sign);
    else passed++;
    tick();
    bus.op_valid = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h0000_0002, 32'hFFFF_FFFA})
      $display("FAIL multu_result: got busy=%b hi=%h lo=%h expected 0 00000002 fffffffa", bus.busy, bus.hi, bus.lo);
    else passed++;
  endtask

  task automatic test_div();
    muldiv_op_t  ops [5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] bs  [5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, 32'hFFFF_FFFB};
    for (int i = 0; i < 5; i++) begin
      logic [31:0] prev_lo;
      logic [31:0] lo_at_32;
      int          n;
      prev_lo      = bus.lo;
      lo_at_32     = 32'd0;
      bus.op_valid = 1'b1;
      bus.op       = ops[i];
      bus.rs_val   = as[i];
      bus.rt_val   = bs[i];
      tick();
      bus.op_valid = 1'b0;
      n = 0;
      while (bus.busy && n < 40) begin
        tick();
        n++;
        if (n == 32) lo_at_32 = bus.lo;
      end
      checks++;
      if (n !== 33) $display("FAIL div%0d_latency: got %0d edges expected 33", i, n);
      else passed++;
      checks++;
      if (lo_at_32 !== prev_lo) $display("FAIL div%0d_early_wb: got lo=%h at E+32 expected %h", i, lo_at_32, prev_lo);
      else passed++;
      checks++;
      if (bus.lo !== elo[i]) $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, elo[i]);
      else passed++;
      checks++;
      if (bus.hi !== ehi[i]) $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, ehi[i]);
      else passed++;
    end
  endtask

  task automatic test_stall_read();
    int bad;
    bad          = 0;
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_val   = 32'h1234_5678;
    bus.rt_val   = 32'h0000_0100;
    tick();
    bus.op_valid = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_sel   = 1'b0;
    for (int i = 0; i < 33; i++) begin
      #1;
      if (!(bus.stall === 1'b1 && bus.rd_valid === 1'b0)) bad++;
      tick();
    end
    #1;
    checks++;
    if (bad !== 0) $display("FAIL read_stall: got %0d bad cycles expected 0", bad);
    else passed++;
    checks++;
    if ({bus.rd_valid, bus.stall, bus.rd_data} !== {1'b1, 1'b0, 32'h0012_3456})
      $display("FAIL read_after_div: got v=%b st=%b d=%h expected 1 0 00123456", bus.rd_valid, bus.stall, bus.rd_data);
    else passed++;
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== 32'h0000_0078) $display("FAIL read_rem: got %h expected 00000078", bus.rd_data);
    else passed++;
    quiet();
  endtask

  task automatic test_back_to_back();
    int n;
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_val   = 32'd100;
    bus.rt_val   = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    repeat (4) tick();
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rs_val   = 32'd6;
    bus.rt_val   = 32'd7;
    #1;
    checks++;
    if (bus.stall !== 1'b1) $display("FAIL held_op_stall: got %b expected 1", bus.stall);
    else passed++;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ({bus.busy, bus.stall, bus.lo, bus.hi} !== {1'b0, 1'b0, 32'd14, 32'd2})
      $display("FAIL b2b_div_done: got busy=%b st=%b lo=%h hi=%h expected 0 0 e 2", bus.busy, bus.stall, bus.lo, bus.hi);
    else passed++;
    tick();
    bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_mult_accept: got busy=%b expected 1", bus.busy);
    else passed++;
    tick();
    checks++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd42})
      $display("FAIL b2b_mult_result: got hi=%h lo=%h expected 0 2a", bus.hi, bus.lo);
    else passed++;
  endtask

  task automatic test_mthi_mtlo();
    bus.op_valid = 1'b1;
    bus.op       = OP_MTHI;
    bus.rs_val   = 32'h1234_5678;
    tick();
    bus.op_valid = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_sel   = 1'b1;
    #1;
    checks++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'h1234_5678})
      $display("FAIL mfhi_next: got v=%b d=%h expected 1 12345678", bus.rd_valid, bus.rd_data);
    else passed++;
    bus.op_valid = 1'b1;
    bus.op       = OP_MTLO;
    bus.rs_val   = 32'hCAFE_F00D;
    bus.rd_sel   = 1'b0;
    #1;
    checks++;
    if ({bus.rd_valid, bus.stall, bus.rd_data} !== {1'b1, 1'b0, 32'd42})
      $display("FAIL mflo_same_cycle: got v=%b st=%b d=%h expected 1 0 0000002a", bus.rd_valid, bus.stall, bus.rd_data);
    else passed++;
    tick();
    quiet();
    #1;
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h1234_5678, 32'hCAFE_F00D})
      $display("FAIL mtlo_write: got busy=%b hi=%h lo=%h expected 0 12345678 cafef00d", bus.busy, bus.hi, bus.lo);
    else passed++;
  endtask

  task automatic test_ignored_ops();
    bus.op_valid = 1'b1;
    bus.op       = 3'd7;
    bus.rs_val   = 32'hDEAD_BEEF;
    bus.rt_val   = 32'd1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) $display("FAIL op7_stall: got %b expected 0", bus.stall);
    else passed++;
    tick();
    bus.op = OP_NONE;
    tick();
    bus.op_valid = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h1234_5678, 32'hCAFE_F00D})
      $display("FAIL ignored_ops: got busy=%b hi=%h lo=%h expected 0 12345678 cafef00d", bus.busy, bus.hi, bus.lo);
    else passed++;
  endtask

  task automatic test_reset_mid_div();
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_val   = 32'd1000;
    bus.rt_val   = 32'd3;
    tick();
    bus.op_valid = 1'b0;
    bus.rd_req   = 1'b1;
    repeat (9) tick();
    #1;
    checks++;
    if ({bus.busy, bus.stall} !== 2'b11) $display("FAIL pre_reset_busy: got %b expected 11", {bus.busy, bus.stall});
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.stall, bus.hi, bus.lo} !== 66'd0)
      $display("FAIL async_reset: got busy=%b st=%b hi=%h lo=%h expected all 0", bus.busy, bus.stall, bus.hi, bus.lo);
    else passed++;
    #2;
    reset = 1'b0;
    bus.rd_req = 1'b0;
    repeat (40) tick();
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== 65'd0)
      $display("FAIL no_wb_after_reset: got busy=%b hi=%h lo=%h expected all 0", bus.busy, bus.hi, bus.lo);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall_read();
    test_back_to_back();
    test_mthi_mtlo();
    test_ignored_ops();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
